// File: rtl/uart_rx_core_if.sv
// Read port of the UART receive FIFO: head word plus per-word error flags.
// Valid/ready handshake; the word is consumed on a clk edge where both are high.
interface uart_rx_core_if #(
  parameter int DATA_BITS = 8
);
  logic                 rd_valid;
  logic                 rd_ready;
  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_perr;
  logic                 rd_ferr;

  modport master (output rd_valid, rd_data, rd_perr, rd_ferr, input rd_ready);
  modport slave  (input rd_valid, rd_data, rd_perr, rd_ferr, output rd_ready);
endinterface

// File: rtl/uart_rx_core.sv
// 16x-oversampled UART receiver; a word lands in the show-ahead FIFO 1 clk after its last stop sample.
// Read side is valid/ready; a frame arriving while the FIFO is full is dropped and sets sticky overrun.
module uart_rx_core #(
  parameter int BAUD_DIV   = 27,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          rx,
  uart_rx_core_if.master                rd,
  output logic                          overrun,
  input  logic                          err_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(BAUD_DIV);
  localparam int WW = DATA_BITS + 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [DW-1:0]        div_cnt;
  logic                 tick;
  state_t               state;
  logic [3:0]           s_cnt;
  logic [3:0]           b_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr_q;
  logic                 ferr_q;
  logic                 stop_idx;
  logic                 last_stop;
  logic                 push_vld;
  logic [WW-1:0]        push_word;

  logic [WW-1:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;
  logic [WW-1:0]        head;
  logic                 pop;
  logic                 full;
  logic                 push_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= 2'b11;
    else      sync_q <= {sync_q[0], rx};
  end
  assign rx_s = sync_q[1];

  assign tick = (div_cnt == DW'(BAUD_DIV - 1));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DW'(1);
  end

  // The last stop sample is folded into the pushed ferr on the same tick.
  assign last_stop = (STOP_BITS == 1) || stop_idx;
  assign push_vld  = tick && (state == STOP) && (s_cnt == 4'd15) && last_stop;
  assign push_word = {ferr_q | ~rx_s, perr_q, shreg};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      s_cnt    <= '0;
      b_cnt    <= '0;
      shreg    <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      stop_idx <= 1'b0;
      busy     <= 1'b0;
    end else if (!en) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else if (tick) begin
      s_cnt <= s_cnt + 4'd1;
      case (state)
        IDLE: if (!rx_s) begin
          state <= START;
          s_cnt <= '0;
          busy  <= 1'b1;
        end
        START: if (s_cnt == 4'd7) begin
          s_cnt    <= '0;
          b_cnt    <= '0;
          perr_q   <= 1'b0;
          ferr_q   <= 1'b0;
          stop_idx <= 1'b0;
          if (!rx_s) begin
            state <= DATA;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        DATA: if (s_cnt == 4'd15) begin
          shreg <= {rx_s, shreg[DATA_BITS-1:1]};
          b_cnt <= b_cnt + 4'd1;
          if (b_cnt == 4'(DATA_BITS - 1)) state <= (PARITY != 0) ? PAR : STOP;
        end
        PAR: if (s_cnt == 4'd15) begin
          perr_q <= (PARITY == 2) ? ~(^shreg ^ rx_s) : (^shreg ^ rx_s);
          state  <= STOP;
        end
        STOP: if (s_cnt == 4'd15) begin
          if (!rx_s) ferr_q <= 1'b1;
          if (last_stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            stop_idx <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pop     = rd.rd_valid && rd.rd_ready;
  assign full    = (count == (AW + 1)'(FIFO_DEPTH));
  assign push_ok = push_vld && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
      if (push_vld && !push_ok) overrun <= 1'b1;
      else if (err_clr)         overrun <= 1'b0;
    end
  end

  assign head        = mem[rd_ptr];
  assign rd.rd_valid = (count != '0);
  assign rd.rd_data  = rd.rd_valid ? head[DATA_BITS-1:0] : '0;
  assign rd.rd_perr  = rd.rd_valid ? head[DATA_BITS]     : 1'b0;
  assign rd.rd_ferr  = rd.rd_valid ? head[DATA_BITS+1]   : 1'b0;
  assign fifo_count  = count;
endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Parametrised UART receive core, successor to the fixed 8-bit receiver. It oversamples `rx` at 16x with mid-bit sampling and validates the start bit. It supports 5–9 data bits, optional even/odd parity and 1 or 2 stop bits. Received words, tagged with per-word error flags, go into an internal show-ahead FIFO with a valid/ready read port for the bus-side consumer.

## Interface
- `BAUD_DIV`, 27: clk cycles per oversample tick (bit time = 16*BAUD_DIV clk); ≥2
- `DATA_BITS`, 8: data bits per frame, 5–9
- `PARITY`, 0: 0 none, 1 even, 2 odd
- `STOP_BITS`, 1: 1 or 2
- `FIFO_DEPTH`, 8: words; power of two, ≥2

- `clk`  in  1  single clock
- `rst`  in  1  asynchronous, active-low reset
- `en`  in  1  receiver enable
- `rx`  in  1  serial line, idle high, asynchronous to clk
- `rd_ready`  in  1  consumer accepts head word
- `rd_valid`  out  1  FIFO non-empty
- `rd_data`  out  DATA_BITS  head word data, LSB = first bit received
- `rd_perr`  out  1  parity error of head word
- `rd_ferr`  out  1  framing error of head word
- `overrun`  out  1  sticky: frame dropped because FIFO full
- `err_clr`  in  1  clears `overrun`
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  words stored
- `busy`  out  1  FSM not in IDLE

## Operation
- `rx` passes through a 2-flop synchroniser (flops reset to 1) → `rx_s`.
- Tick generator: counter 0..BAUD_DIV-1, free-running, one-cycle `tick` at BAUD_DIV-1.
- All FSM activity occurs on `tick` cycles only. `s_cnt` is a 4-bit tick counter and `b_cnt` is a bit counter.
- IDLE: `rx_s`==0 on tick → START, `s_cnt`=0.
- START: at `s_cnt`==7 (mid start bit), if `rx_s`==0 → DATA with `s_cnt`=0 and `b_cnt`=0. Otherwise glitch → IDLE; nothing is recorded.
- DATA: at `s_cnt`==15, shift `rx_s` in LSB-first and increment `b_cnt`. After DATA_BITS bits → PARITY if PARITY≠0, else STOP.
- PARITY: at `s_cnt`==15, sample `p`.
  - Even: `perr` = ^data ^ p.
  - Odd: `perr` = ~(^data ^ p).
  - PARITY=0: `perr`=0.
- STOP: sample at each `s_cnt`==15, STOP_BITS times. `ferr`=1 if any stop sample is 0.
  - After the final stop sample: push {ferr, perr, data}, then → IDLE on the same tick.
  - A break (all-zero data plus `ferr`) is pushed like any word.
- `en`=0: FSM forced to IDLE on next clk and any partial frame is discarded. FIFO, flags and read port are unaffected.
- FIFO push is accepted if `fifo_count`<FIFO_DEPTH or a pop occurs in the same cycle. Otherwise the word is dropped and `overrun` is set.
- Pop occurs when `rd_valid` && `rd_ready`. Simultaneous push and pop leaves `fifo_count` unchanged.
- `rd_data`/`rd_perr`/`rd_ferr` are forced to 0 while `rd_valid`=0.
- `overrun`: set by a dropped push, cleared by `err_clr`. Set wins if both occur in the same cycle.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.

## Timing
- Reset (`rst`=0, async): FSM IDLE; all counters 0; `rd_valid`=0, `rd_data`=0, `rd_perr`=0, `rd_ferr`=0, `overrun`=0, `fifo_count`=0, `busy`=0. FIFO storage is not reset.
- `rx` edge → `rx_s`: 2 clk.
- Start detection is up to one tick late, so samples fall within ±1 tick of bit centre.
- Push occurs on the final stop-sample tick. `rd_valid` and `fifo_count` update 1 clk later.
- The pop is registered on the handshake clk edge. The next head appears in the following cycle (show-ahead).
- `busy` rises 1 clk after the start-detect tick and falls 1 clk after the final stop-sample tick, or 1 clk after a glitch reject or `en`=0.
- Back-to-back frames with zero idle time are received because IDLE is re-entered at mid stop bit.
- Reset mid-frame discards the frame; reception resumes at the next falling edge after release.

## Test plan
All scenarios use BAUD_DIV=4 (bit = 64 clk).
- 8N1, send 0xA5 → `rd_valid`=1, `rd_data`=0xA5, `rd_perr`=0, `rd_ferr`=0, `fifo_count`=1. Pulse `rd_ready` → `rd_valid`=0, `fifo_count`=0.
- Drive `rx` low for 12 clk, then high → `busy` pulses then returns to 0; `rd_valid` stays 0; no word stored.
- PARITY=1: send 0x03 with p=0 → `rd_perr`=0. Send 0x03 with p=1 → `rd_perr`=1. PARITY=2: send 0x03 with p=1 → `rd_perr`=0.
- Send 0x5A with stop bit driven 0 → word stored, `rd_data`=0x5A, `rd_ferr`=1. STOP_BITS=2 with second stop bit 0 → `rd_ferr`=1.
- FIFO_DEPTH=4: send 0x11, 0x22, 0x33, 0x44, 0x55 with `rd_ready`=0 → `fifo_count`=4, `overrun`=1, reads return 0x11..0x44 in order. Pulse `err_clr` → `overrun`=0.
- Deassert `en` (or `rst`) midway through data bits of 0xC3 → no word stored, `busy`=0. Re-enable and send 0x3C → `rd_data`=0x3C with no errors. DATA_BITS=9: send 0x1FF → `rd_data`=0x1FF.
